// File: rtl/fetch_prefetch_buffer_if.sv
// fetch_prefetch_buffer_if: instruction-memory and decode handshakes of the fetch front end
interface fetch_prefetch_buffer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: latency-tolerant instruction fetch with PC-tagged prefetch FIFO and redirect flush
module fetch_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_prefetch_buffer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
  logic          rvalid, issue, push, pop, valid;
  assign redir_pc        = {bus.redirect_pc[31:2], 2'b00};
  assign valid           = cnt_q != '0;
  // Queued plus in-flight never exceeds DEPTH, so every response has a slot
  assign bus.imem_req    = !rst && !bus.redirect && (32'(cnt_q) + 32'(out_q) < DEPTH);
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = valid ? word_mem[rd_q] : '0;
  assign bus.instr_pc    = valid ? pc_mem[rd_q] : '0;
  assign rvalid          = bus.imem_rvalid && out_q != '0;
  assign issue           = bus.imem_req && bus.imem_gnt;
  assign push            = rvalid && disc_q == '0 && !bus.redirect;
  assign pop             = valid && bus.instr_ready;
  always_comb begin
    fetch_pc_d = bus.redirect ? redir_pc : fetch_pc_q + (issue ? 32'd4 : 32'd0);
    resp_pc_d  = bus.redirect ? redir_pc : resp_pc_q + (push ? 32'd4 : 32'd0);
    rd_d       = bus.redirect ? '0 : rd_q + AW'(pop);
    wr_d       = bus.redirect ? '0 : wr_q + AW'(push);
    cnt_d      = bus.redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    out_d      = out_q + CW'(issue) - CW'(rvalid);
    disc_d     = bus.redirect ? out_q - CW'(rvalid) : disc_q - CW'(rvalid && disc_q != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_q]   <= resp_pc_q;
      word_mem[wr_q] <= bus.imem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(bus.imem_rvalid && out_q == '0));
  end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: randomized and directed fetch traffic checked against a queue-based reference
module tb_fetch_prefetch_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_prefetch_buffer_if bus();
  fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  req_t        pend[$];
  logic [31:0] fifo[$];
  logic [31:0] exp_fetch = RESET_PC;
  int          ep = 0, cyc = 0, lat = 1, n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // One cycle: drive memory/decode inputs, check outputs, then apply the edge to the model
  task automatic step(input logic g, input logic rdy, input logic rd, input logic [31:0] rpc, input logic r);
    logic resp, exp_req, pop, gr;
    req_t e;
    resp = !r && pend.size() != 0 && pend[0].due <= cyc;
    rst = r;
    bus.imem_gnt = g;
    bus.instr_ready = rdy;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.imem_rvalid = resp;
    bus.imem_rdata = resp ? pend[0].addr ^ KEY : $urandom;
    #1;
    exp_req = !r && !rd && (fifo.size() + pend.size() < DEPTH);
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (!r) chk("imem_addr", bus.imem_addr, exp_fetch);
    chk("instr_valid", 32'(bus.instr_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) begin
      chk("instr_pc", bus.instr_pc, fifo[0]);
      chk("instr", bus.instr, fifo[0] ^ KEY);
    end
    pop = fifo.size() != 0 && rdy;
    gr = exp_req && g;
    @(posedge clk);
    if (r) begin
      fifo.delete();
      pend.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (resp) e = pend.pop_front();
      if (rd) begin
        fifo.delete();
        ep++;
        exp_fetch = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(fifo.pop_front());
        if (resp && e.ep == ep) fifo.push_back(e.addr);
        if (gr) begin
          pend.push_back('{exp_fetch, cyc + lat, ep});
          exp_fetch += 32'd4;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.instr_pc, 32'd0);
    // Sustained stream with a 1-cycle memory
    lat = 1;
    for (int i = 0; i < 30; i++) begin
      step(1, 1, 0, 0, 0);
      if (i >= 2) chk("stream_valid", 32'(bus.instr_valid), 32'd1);
    end
    // Decode stall fills the queue and stops requests
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    chk("full_req", 32'(bus.imem_req), 32'd0);
    chk("full_valid", 32'(bus.instr_valid), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    // Redirect with slow memory and responses in flight
    lat = 3;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0103, 0);
    chk("redir_flush", 32'(bus.instr_valid), 32'd0);
    chk("redir_discard", 32'(dut.disc_q), 32'(pend.size()));
    for (int i = 0; i < 20 && !bus.instr_valid; i++) step(1, 1, 0, 0, 0);
    chk("redir_valid", 32'(bus.instr_valid), 32'd1);
    chk("redir_pc", bus.instr_pc, 32'h0000_0100);
    chk("redir_word", bus.instr, 32'h0000_0100 ^ KEY);
    // Redirect coinciding with a response and a decode pop
    lat = 2;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    chk("coinc_rvalid_due", 32'(pend.size() != 0 && pend[0].due <= cyc), 32'd1);
    step(1, 1, 1, 32'h0000_2000, 0);
    chk("coinc_flush", 32'(bus.instr_valid), 32'd0);
    chk("coinc_discard", 32'(dut.disc_q), 32'(pend.size()));
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    // Address wrap at the top of memory
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    lat = 1;
    step(1, 1, 1, 32'hFFFF_FFF8, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    // Random traffic: grant, ready, latency and redirects
    for (int b = 0; b < 20; b++) begin
      lat = int'($urandom_range(1, 4));
      for (int i = 0; i < 20; i++)
        step($urandom % 4 != 0, $urandom % 3 != 0, $urandom % 16 == 0, $urandom, 0);
    end
    // Reset with queued and outstanding fetches
    lat = 3;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", bus.instr, 32'd0);
    chk("mid_rst_pc", bus.instr_pc, 32'd0);
    chk("mid_rst_addr", bus.imem_addr, RESET_PC);
    lat = 1;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
